// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - tick-driven intersection phase sequencer with binary/BCD countdown and night flashing mode
module traffic_phase_controller #(
  parameter int GREEN_SEC   = 25,
  parameter int YELLOW_SEC  = 3,
  parameter int ALL_RED_SEC = 2,
  parameter int SEC_BITS    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                run,
  input  logic                night_mode,
  output logic [2:0]          ns_light,
  output logic [2:0]          ew_light,
  output logic [SEC_BITS-1:0] sec_left,
  output logic [3:0]          sec_tens,
  output logic [3:0]          sec_ones,
  output logic [2:0]          phase,
  output logic                phase_change
);

  localparam logic [2:0] ALL_RED_A = 3'd0;
  localparam logic [2:0] NS_GREEN  = 3'd1;
  localparam logic [2:0] NS_YELLOW = 3'd2;
  localparam logic [2:0] ALL_RED_B = 3'd3;
  localparam logic [2:0] EW_GREEN  = 3'd4;
  localparam logic [2:0] EW_YELLOW = 3'd5;
  localparam logic [2:0] NIGHT     = 3'd6;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  // Binary and BCD load values, fixed at elaboration.
  localparam logic [SEC_BITS-1:0] GREEN_LD   = SEC_BITS'(GREEN_SEC);
  localparam logic [SEC_BITS-1:0] YELLOW_LD  = SEC_BITS'(YELLOW_SEC);
  localparam logic [SEC_BITS-1:0] ALL_RED_LD = SEC_BITS'(ALL_RED_SEC);
  localparam logic [3:0] GREEN_T   = 4'(GREEN_SEC / 10);
  localparam logic [3:0] GREEN_O   = 4'(GREEN_SEC % 10);
  localparam logic [3:0] YELLOW_T  = 4'(YELLOW_SEC / 10);
  localparam logic [3:0] YELLOW_O  = 4'(YELLOW_SEC % 10);
  localparam logic [3:0] ALL_RED_T = 4'(ALL_RED_SEC / 10);
  localparam logic [3:0] ALL_RED_O = 4'(ALL_RED_SEC % 10);

  localparam bit PARAMS_OK = (GREEN_SEC >= 1) && (GREEN_SEC <= 99) &&
                             (YELLOW_SEC >= 1) && (YELLOW_SEC <= 99) &&
                             (ALL_RED_SEC >= 1) && (ALL_RED_SEC <= 99) &&
                             (SEC_BITS >= 7) && (SEC_BITS <= 31);

  // Refuse to elaborate with durations outside 1..99 or a counter too narrow for 99.
  if (!PARAMS_OK) begin : g_param_check
    $error("traffic_phase_controller: durations must be 1..99 and SEC_BITS must hold 99");
  end

  logic                flash;
  logic [2:0]          phase_n;
  logic [SEC_BITS-1:0] sec_n;
  logic [3:0]          tens_n;
  logic [3:0]          ones_n;
  logic                flash_n;
  logic                change_n;
  logic                load;
  logic [2:0]          ns_n;
  logic [2:0]          ew_n;

  // Successor in the normal daytime rotation.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      ALL_RED_A: next_phase = NS_GREEN;
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = ALL_RED_B;
      ALL_RED_B: next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      default:   next_phase = ALL_RED_A;
    endcase
  endfunction

  // Next-state, countdown and lamp decode; lamps follow the state being entered.
  always_comb begin
    phase_n  = phase;
    sec_n    = sec_left;
    tens_n   = sec_tens;
    ones_n   = sec_ones;
    flash_n  = flash;
    change_n = 1'b0;
    load     = 1'b0;
    ns_n     = LAMP_RED;
    ew_n     = LAMP_RED;

    if (phase == 3'd7) begin
      // Unreachable encoding: recover without waiting for a tick.
      phase_n  = ALL_RED_A;
      flash_n  = 1'b0;
      load     = 1'b1;
      change_n = 1'b1;
    end else if (run && tick) begin
      if (phase == NIGHT) begin
        if (night_mode) begin
          flash_n = ~flash;
        end else begin
          phase_n  = ALL_RED_A;
          flash_n  = 1'b0;
          load     = 1'b1;
          change_n = 1'b1;
        end
      end else if (night_mode) begin
        // Night request preempts the countdown, even on the last second.
        phase_n  = NIGHT;
        sec_n    = '0;
        tens_n   = 4'd0;
        ones_n   = 4'd0;
        flash_n  = 1'b1;
        change_n = 1'b1;
      end else if (sec_left == SEC_BITS'(1)) begin
        phase_n  = next_phase(phase);
        load     = 1'b1;
        change_n = 1'b1;
      end else begin
        sec_n = sec_left - SEC_BITS'(1);
        if (sec_ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = sec_tens - 4'd1;
        end else begin
          ones_n = sec_ones - 4'd1;
        end
      end
    end

    if (load) begin
      case (phase_n)
        NS_GREEN, EW_GREEN: begin
          sec_n  = GREEN_LD;
          tens_n = GREEN_T;
          ones_n = GREEN_O;
        end
        NS_YELLOW, EW_YELLOW: begin
          sec_n  = YELLOW_LD;
          tens_n = YELLOW_T;
          ones_n = YELLOW_O;
        end
        default: begin
          sec_n  = ALL_RED_LD;
          tens_n = ALL_RED_T;
          ones_n = ALL_RED_O;
        end
      endcase
    end

    case (phase_n)
      NS_GREEN:  ns_n = LAMP_GREEN;
      NS_YELLOW: ns_n = LAMP_YELLOW;
      EW_GREEN:  ew_n = LAMP_GREEN;
      EW_YELLOW: ew_n = LAMP_YELLOW;
      NIGHT: begin
        ns_n = flash_n ? LAMP_YELLOW : LAMP_OFF;
        ew_n = flash_n ? LAMP_YELLOW : LAMP_OFF;
      end
      default: begin
        ns_n = LAMP_RED;
        ew_n = LAMP_RED;
      end
    endcase
  end

  // State, counters and lamp registers; reset parks the junction in all-red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= ALL_RED_A;
      sec_left     <= ALL_RED_LD;
      sec_tens     <= ALL_RED_T;
      sec_ones     <= ALL_RED_O;
      flash        <= 1'b0;
      phase_change <= 1'b0;
      ns_light     <= LAMP_RED;
      ew_light     <= LAMP_RED;
    end else begin
      phase        <= phase_n;
      sec_left     <= sec_n;
      sec_tens     <= tens_n;
      sec_ones     <= ones_n;
      flash        <= flash_n;
      phase_change <= change_n;
      ns_light     <= ns_n;
      ew_light     <= ew_n;
    end
  end

endmodule
